// File: rtl/disp_share_arb_if.sv
// Handshake bundle between the data producers and the display arbiter.
// Latency: none (wires only).
// Backpressure: none; a requester simply keeps REQ high until it sees GNT.
//
// Signals:
//   REQ        per-source level request
//   DATA       packed per-source words, source i at [i*DATA_W +: DATA_W]
//   GNT        one-hot grant, zero when idle
//   OWNER      index of the current owner, 0 when idle
//   DISP_DATA  word forwarded to the hex display driver
//   DISP_VALID display enable, 0 blanks the anodes
interface disp_share_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        REQ;
  logic [N_REQ*DATA_W-1:0] DATA;
  logic [N_REQ-1:0]        GNT;
  logic [OW-1:0]           OWNER;
  logic [DATA_W-1:0]       DISP_DATA;
  logic                    DISP_VALID;

  // Arbiter side.
  modport slave (
    input  REQ, DATA,
    output GNT, OWNER, DISP_DATA, DISP_VALID
  );

  // Producer / display side.
  modport master (
    output REQ, DATA,
    input  GNT, OWNER, DISP_DATA, DISP_VALID
  );
endinterface

// File: rtl/disp_share_arb.sv
// Round-robin arbiter sharing one hex display path among N_REQ sources,
// with a minimum on-screen hold of HOLD_CYC cycles per owner.
// Latency: grant and display word one cycle after the request edge; backpressure: none, losers wait on REQ.
//
// Ports:
//   CLK  system clock
//   RST  synchronous active-high reset
//   bus  disp_share_arb_if.slave (REQ, DATA in; GNT, OWNER, DISP_DATA, DISP_VALID out)
//
// Optional build macro DISP_ARB_PREEMPT_EN: source 0 becomes urgent and
// takes the display immediately from any other owner.
module disp_share_arb #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 16,
  parameter int HOLD_CYC = 50000000
) (
  input  logic             CLK,
  input  logic             RST,
  disp_share_arb_if.slave  bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYC - 1);
  localparam logic [OW-1:0] LAST_RST    = OW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     last_q, last_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;

  // First requester strictly after 'base', wrapping. If only 'base' itself
  // requests, the search comes back around to it.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0] base);
    logic [OW-1:0] idx;
    logic [OW-1:0] res;
    logic          hit;
    idx = base;
    res = '0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == LAST_RST) ? '0 : idx + 1'b1;
      if (!hit && r[idx]) begin
        hit = 1'b1;
        res = idx;
      end
    end
    return res;
  endfunction

  logic [OW-1:0]    rr_idx;
  logic [N_REQ-1:0] others;
  logic             preempt;
  logic             take;
  logic [OW-1:0]    take_idx;

  // While owning, last_q equals owner_q, so one search base serves both states.
  assign rr_idx = rr_pick(bus.REQ, last_q);
  assign others = bus.REQ & ~gnt_q;

`ifdef DISP_ARB_PREEMPT_EN
  assign preempt = (owner_q != '0) && bus.REQ[0];
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    take         = 1'b0;
    take_idx     = rr_idx;

    if (state_q == ST_IDLE) begin
      gnt_d        = '0;
      owner_d      = '0;
      disp_valid_d = 1'b0;
      take         = |bus.REQ;
    end else begin
      // Live tracking of the owner's word only while it keeps requesting.
      if (bus.REQ[owner_q]) begin
        disp_data_d = bus.DATA[int'(owner_q)*DATA_W +: DATA_W];
      end
      if (preempt) begin
        take     = 1'b1;
        take_idx = '0;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (|others) begin
        take = 1'b1;
      end else if (!bus.REQ[owner_q]) begin
        state_d      = ST_IDLE;
        gnt_d        = '0;
        owner_d      = '0;
        disp_valid_d = 1'b0;
      end
      // Owner alone and still requesting: keep it, counter parked at 0.
    end

    if (take) begin
      state_d      = ST_OWN;
      gnt_d        = ONE_HOT0 << take_idx;
      owner_d      = take_idx;
      last_d       = take_idx;
      cnt_d        = HOLD_RELOAD;
      disp_valid_d = 1'b1;
      disp_data_d  = bus.DATA[int'(take_idx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= LAST_RST;
      gnt_q        <= '0;
      owner_q      <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign bus.GNT        = gnt_q;
  assign bus.OWNER      = owner_q;
  assign bus.DISP_DATA  = disp_data_q;
  assign bus.DISP_VALID = disp_valid_q;
endmodule
